// File: rtl/input_conditioner.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | input_conditioner: sync, debounce, press pulse and DAS/ARR auto-repeat |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module input_conditioner #(
  parameter int         DEBOUNCE_CYCLES = 250_000,
  parameter int         DAS_CYCLES      = 4_000_000,
  parameter int         ARR_CYCLES      = 1_250_000,
  parameter logic [4:0] REPEAT_MASK     = 5'b00011
) (
  input  logic       hz100,
  input  logic       reset,
  input  logic [4:0] btn_i,
  input  logic       en_i,
  output logic [4:0] level_o,
  output logic [4:0] pulse_o
);

  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES);
  localparam int RPT_MAX = (DAS_CYCLES > ARR_CYCLES) ? DAS_CYCLES : ARR_CYCLES;
  localparam int RPT_W   = $clog2(RPT_MAX);

  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] DAS_LAST = RPT_W'(DAS_CYCLES - 1);
  localparam logic [RPT_W-1:0] ARR_LAST = RPT_W'(ARR_CYCLES - 1);

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_e;

  logic [4:0] sync1_q, sync1_d;
  logic [4:0] sync2_q, sync2_d;
  logic [4:0] level_nxt;
  logic       lr_both;

  always_comb begin
    sync1_d = btn_i;
    sync2_d = sync1_q;
  end

  always_ff @(posedge hz100) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  // Judged on next-cycle levels so a repeat cannot slip out on the edge where the overlap begins.
  assign lr_both = level_nxt[0] & level_nxt[1];

  for (genvar i = 0; i < 5; i++) begin : g_ch
    logic            level_q, level_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            pulse_q, pulse_d;
    logic            rise;
    logic            rpt_pulse;

    always_comb begin
      level_d  = level_q;
      db_cnt_d = '0;
      if (sync2_q[i] != level_q) begin
        if (db_cnt_q == DB_LAST) begin
          level_d = ~level_q;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end
    end

    assign rise         = level_d & ~level_q;
    assign level_nxt[i] = level_d;

    if (REPEAT_MASK[i]) begin : g_rpt
      rpt_state_e       state_q, state_d;
      logic [RPT_W-1:0] cnt_q, cnt_d;

      always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rpt_pulse = 1'b0;
        if (!level_d || !en_i || lr_both) begin
          state_d = RPT_IDLE;
          cnt_d   = '0;
        end else begin
          case (state_q)
            RPT_IDLE: begin
              if (rise) begin
                state_d = RPT_DELAY;
                cnt_d   = '0;
              end
            end
            RPT_DELAY: begin
              if (cnt_q == DAS_LAST) begin
                rpt_pulse = 1'b1;
                state_d   = RPT_REPEAT;
                cnt_d     = '0;
              end else begin
                cnt_d = cnt_q + RPT_W'(1);
              end
            end
            RPT_REPEAT: begin
              if (cnt_q == ARR_LAST) begin
                rpt_pulse = 1'b1;
                cnt_d     = '0;
              end else begin
                cnt_d = cnt_q + RPT_W'(1);
              end
            end
            default: begin
              state_d = RPT_IDLE;
              cnt_d   = '0;
            end
          endcase
        end
      end

      always_ff @(posedge hz100) begin
        if (reset) begin
          state_q <= RPT_IDLE;
          cnt_q   <= '0;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
        end
      end
    end else begin : g_no_rpt
      assign rpt_pulse = 1'b0;
    end

    assign pulse_d = (rise & en_i) | rpt_pulse;

    always_ff @(posedge hz100) begin
      if (reset) begin
        level_q  <= 1'b0;
        db_cnt_q <= '0;
        pulse_q  <= 1'b0;
      end else begin
        level_q  <= level_d;
        db_cnt_q <= db_cnt_d;
        pulse_q  <= pulse_d;
      end
    end

    assign level_o[i] = level_q;
    assign pulse_o[i] = pulse_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_input_conditioner.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_input_conditioner: directed stimulus with a pulse scoreboard        |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_input_conditioner;

  logic       hz100 = 1'b0;
  logic       reset;
  logic [4:0] btn_i;
  logic       en_i;
  logic [4:0] level_o;
  logic [4:0] pulse_o;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         cyc;
    logic [4:0] val;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  input_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .DAS_CYCLES     (10),
    .ARR_CYCLES     (3),
    .REPEAT_MASK    (5'b00011)
  ) dut (
    .hz100  (hz100),
    .reset  (reset),
    .btn_i  (btn_i),
    .en_i   (en_i),
    .level_o(level_o),
    .pulse_o(pulse_o)
  );

  always #5 hz100 = ~hz100;
  always @(posedge hz100) cyc <= cyc + 1;

  // Pulse monitor: every nonzero pulse_o must match the oldest expectation.
  always @(negedge hz100) begin
    if (!reset) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL pulse_missed: saw nothing, expected pulse_o=%h at cycle %0d (now %0d)",
                 exp_q[0].val, exp_q[0].cyc, cyc);
        exp_q.delete(0);
      end
      if (pulse_o != 5'h00) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pulse_unexpected: pulse_o=%h at cycle %0d, expected none", pulse_o, cyc);
        end else begin
          mon_e = exp_q[0];
          exp_q.delete(0);
          if (mon_e.cyc != cyc || mon_e.val !== pulse_o) begin
            errors++;
            $display("FAIL pulse_match: pulse_o=%h at cycle %0d, expected %h at cycle %0d",
                     pulse_o, cyc, mon_e.val, mon_e.cyc);
          end
        end
      end
    end
  end

  task automatic go(input int c);
    while (cyc < c) @(negedge hz100);
  endtask

  task automatic push(input int c, input logic [4:0] v);
    exp_t t;
    t.cyc = c;
    t.val = v;
    exp_q.push_back(t);
  endtask

  task automatic chk_lvl(input string name, input logic [4:0] exp);
    checks++;
    if (level_o !== exp) begin
      errors++;
      $display("FAIL %s: level_o=%h expected %h (cycle %0d)", name, level_o, exp, cyc);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int m;
    reset = 1'b1;
    btn_i = 5'h1F;
    en_i  = 1'b1;

    // Reset held with all buttons pressed
    repeat (3) begin
      @(negedge hz100);
      chk_lvl("rst_level_zero", 5'h00);
      checks++;
      if (pulse_o !== 5'h00) begin
        errors++;
        $display("FAIL rst_pulse_zero: pulse_o=%h expected 00", pulse_o);
      end
    end
    reset = 1'b0;
    n = cyc;
    push(n + 6, 5'h1F);
    go(n + 5); chk_lvl("rst_pre_debounce", 5'h00);
    go(n + 6); chk_lvl("rst_all_pressed", 5'h1F);
    go(n + 12);
    n = cyc;
    btn_i = 5'h00;
    go(n + 5); chk_lvl("rel_all_pre", 5'h1F);
    go(n + 6); chk_lvl("rel_all_done", 5'h00);
    go(n + 12);

    // Bounce on rotate_r: 2-cycle toggles never get through
    n = cyc;
    for (int k = 0; k < 10; k++) begin
      btn_i = (k % 2 == 0) ? 5'h04 : 5'h00;
      @(negedge hz100);
      chk_lvl("bounce_hold_low", 5'h00);
      @(negedge hz100);
    end
    n = cyc;
    btn_i = 5'h04;
    push(n + 6, 5'h04);
    go(n + 5); chk_lvl("bounce_pre", 5'h00);
    go(n + 6); chk_lvl("bounce_rise", 5'h04);
    go(n + 10);
    n = cyc;
    btn_i = 5'h00;
    go(n + 6); chk_lvl("bounce_release", 5'h00);
    go(n + 10);

    // Repeat on left: press, DAS, then ARR train until release lands
    n = cyc;
    btn_i = 5'h01;
    push(n + 6, 5'h01);
    for (int t = n + 16; t <= n + 45; t += 3) push(t, 5'h01);
    go(n + 40);
    btn_i = 5'h00;
    go(n + 45); chk_lvl("rpt_still_high", 5'h01);
    go(n + 46); chk_lvl("rpt_released", 5'h00);
    go(n + 55);

    // Start channel: single pulse however long it is held
    n = cyc;
    btn_i = 5'h10;
    push(n + 6, 5'h10);
    go(n + 20); chk_lvl("start_held", 5'h10);
    go(n + 40);
    btn_i = 5'h00;
    go(n + 46); chk_lvl("start_released", 5'h00);
    go(n + 52);

    // Left held, right joins: right pulses once, repeats stop and stay stopped
    n = cyc;
    btn_i = 5'h01;
    push(n + 6, 5'h01);
    push(n + 16, 5'h01);
    push(n + 18, 5'h02);
    go(n + 12);
    btn_i = 5'h03;
    go(n + 20); chk_lvl("lr_both_held", 5'h03);
    go(n + 30);
    btn_i = 5'h01;
    go(n + 36); chk_lvl("lr_right_released", 5'h01);
    go(n + 45);
    btn_i = 5'h00;
    go(n + 51); chk_lvl("lr_all_released", 5'h00);
    go(n + 60);

    // Enable low at press, raised while held: no pulses at all
    en_i = 1'b0;
    n = cyc;
    btn_i = 5'h02;
    go(n + 8); chk_lvl("en_level_unaffected", 5'h02);
    go(n + 10);
    en_i = 1'b1;
    go(n + 30);
    btn_i = 5'h00;
    go(n + 36); chk_lvl("en_released", 5'h00);
    go(n + 40);
    m = cyc;
    btn_i = 5'h02;
    push(m + 6, 5'h02);
    for (int t = m + 16; t <= m + 35; t += 3) push(t, 5'h02);
    go(m + 30);
    btn_i = 5'h00;
    go(m + 36); chk_lvl("en_repress_released", 5'h00);
    go(m + 45);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expectations: %0d pending, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
